// File: rtl/kgp_wb_pkg.sv
// -----------------------------------------------------------------------------
// kgp_wb_pkg
// Shared types and constants for the KGP-RISC writeback sequencer:
//   - register-file write-select encodings (dst_sel)
//   - result-source encodings (src_sel)
//   - queue entry layout and head FSM state type
//   - small helpers for entry construction and hazard-mask decode
// -----------------------------------------------------------------------------
package kgp_wb_pkg;

  // Register-file write-select encodings (also the wb_writeReg encoding)
  localparam logic [1:0] WB_NONE  = 2'b00;
  localparam logic [1:0] WB_LINK  = 2'b01;
  localparam logic [1:0] WB_RS    = 2'b10;
  localparam logic [1:0] WB_RT    = 2'b11;

  // Result-source encodings; 2'b11 is reserved and behaves like SRC_ALU
  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic [1:0]  dst_sel;
    logic [4:0]  addr;
    logic [1:0]  src_sel;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'b00,
    ST_ISSUE    = 2'b01,
    ST_WAIT_MEM = 2'b10
  } wb_state_e;

  // Resolve the target register and capture the data known at enqueue time.
  // Loads carry zero data; their value is supplied later by memory.
  function automatic wb_entry_t make_entry(input logic [1:0]  dst,
                                           input logic [1:0]  src,
                                           input logic [4:0]  rs,
                                           input logic [4:0]  rt,
                                           input logic [31:0] alu,
                                           input logic [31:0] pc);
    wb_entry_t e;
    e.dst_sel = dst;
    e.src_sel = src;
    case (dst)
      WB_RS:   e.addr = rs;
      WB_RT:   e.addr = rt;
      WB_LINK: e.addr = LINK_REG;
      default: e.addr = 5'd0;
    endcase
    case (src)
      SRC_LINK: e.data = pc + 32'd4;
      SRC_MEM:  e.data = 32'd0;
      default:  e.data = alu;
    endcase
    return e;
  endfunction

  function automatic logic is_load(input logic [1:0] src);
    return (src == SRC_MEM);
  endfunction

  function automatic logic [31:0] reg_onehot(input logic [4:0] a);
    return (32'd1 << a);
  endfunction

endpackage

// File: rtl/wb_queue.sv
// -----------------------------------------------------------------------------
// wb_queue
// In-order FIFO of writeback entries.
//   clk, rst_n       : clock, asynchronous active-low reset (flushes queue)
//   push_i/entry_i   : enqueue one entry (ignored when full)
//   pop_i            : dequeue the head (ignored when empty)
//   full_o, empty_o  : occupancy flags;  count_o : occupancy
//   head_o           : entry at the head
//   next_src_o       : src_sel of the entry behind the head
//   vld_o, addr_o    : per-slot valid bits and target addresses (hazard view)
// -----------------------------------------------------------------------------
module wb_queue
  import kgp_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  wb_entry_t                push_entry_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output wb_entry_t                head_o,
  output logic [1:0]               next_src_o,
  output logic [DEPTH-1:0]         vld_o,
  output logic [4:0]               addr_o [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  wb_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_q;
  logic [PW-1:0]     wr_q;
  logic [PW:0]       cnt_q;
  logic [DEPTH-1:0]  vld_q;
  logic [DEPTH-1:0]  vld_d;
  logic [PW-1:0]     rd_nxt_s;
  logic              do_push_s;
  logic              do_pop_s;

  assign full_o     = (cnt_q == DEPTH_C);
  assign empty_o    = (cnt_q == (PW+1)'(0));
  assign count_o    = cnt_q;
  assign do_push_s  = push_i && !full_o;
  assign do_pop_s   = pop_i && !empty_o;
  assign rd_nxt_s   = rd_q + PW'(1);
  assign head_o     = mem_q[rd_q];
  assign next_src_o = mem_q[rd_nxt_s].src_sel;
  assign vld_o      = vld_q;

  // Next per-slot valid bits: clear the popped slot, set the pushed slot
  always_comb begin
    vld_d = vld_q;
    if (do_pop_s) begin
      vld_d[rd_q] = 1'b0;
    end else begin
      vld_d = vld_d;
    end
    if (do_push_s) begin
      vld_d[wr_q] = 1'b1;
    end else begin
      vld_d = vld_d;
    end
  end

  // Slot address view for the hazard mask
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_o[i] = mem_q[i].addr;
    end
  end

  // Storage, pointers and occupancy; pointers wrap modulo DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_q] <= push_entry_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_q <= rd_nxt_s;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/writeback_sequencer.sv
// -----------------------------------------------------------------------------
// writeback_sequencer
// Buffers completed results and retires them in order to the register file,
// at most one write per cycle. Loads stall at the head until memory returns.
//   clk, rst                : clock, asynchronous active-low reset
//   req_*                   : result offer from execute/memory (valid/ready)
//   mem_rvalid, mem_rdata   : load data return (one-cycle pulse)
//   wb_writeReg/addr/Data   : registered register-file write port
//   pend_mask               : one bit per register targeted by a queued entry
//   err                     : sticky, memory data arrived with no load at head
// -----------------------------------------------------------------------------
module writeback_sequencer
  import kgp_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_dst_sel,
  input  logic [1:0]  req_src_sel,
  input  logic [4:0]  req_rs,
  input  logic [4:0]  req_rt,
  input  logic [31:0] req_alu_result,
  input  logic [31:0] req_pc,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  wb_writeReg,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_writeData,
  output logic [31:0] pend_mask,
  output logic        err
);

  localparam int PW = $clog2(DEPTH);

  wb_state_e    state_q, state_d;
  logic [1:0]   wb_sel_q, wb_sel_d;
  logic [4:0]   wb_addr_q, wb_addr_d;
  logic [31:0]  wb_data_q, wb_data_d;
  logic         err_q, err_d;

  logic         push_s;
  logic         pop_s;
  wb_entry_t    push_entry_s;
  logic         q_full_s;
  logic         q_empty_s;
  logic [PW:0]  q_count_s;
  wb_entry_t    q_head_s;
  logic [1:0]   q_next_src_s;
  logic [DEPTH-1:0] q_vld_s;
  logic [4:0]   q_addr_s [DEPTH];
  logic [PW:0]  cnt_nxt_s;
  logic [1:0]   nsrc_s;
  logic [31:0]  pend_mask_s;

  // Ready only reflects occupancy, never the same-cycle pop
  assign req_ready    = rst && !q_full_s;
  // dst_sel 00 completes the handshake but is dropped here
  assign push_s       = req_valid && req_ready && (req_dst_sel != WB_NONE);
  assign push_entry_s = make_entry(req_dst_sel, req_src_sel, req_rs, req_rt,
                                   req_alu_result, req_pc);

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (rst),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .pop_i        (pop_s),
    .full_o       (q_full_s),
    .empty_o      (q_empty_s),
    .count_o      (q_count_s),
    .head_o       (q_head_s),
    .next_src_o   (q_next_src_s),
    .vld_o        (q_vld_s),
    .addr_o       (q_addr_s)
  );

  // Head FSM outputs: issue the head write, pop, and flag stray load data
  always_comb begin
    wb_sel_d  = WB_NONE;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;
    pop_s     = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        wb_sel_d  = q_head_s.dst_sel;
        wb_addr_d = q_head_s.addr;
        wb_data_d = q_head_s.data;
        pop_s     = 1'b1;
        err_d     = err_q | mem_rvalid;
      end
      ST_WAIT_MEM: begin
        if (mem_rvalid) begin
          wb_sel_d  = q_head_s.dst_sel;
          wb_addr_d = q_head_s.addr;
          wb_data_d = mem_rdata;
          pop_s     = 1'b1;
        end else begin
          pop_s     = 1'b0;
        end
      end
      ST_EMPTY: begin
        err_d = err_q | mem_rvalid;
      end
      default: begin
        wb_sel_d = WB_NONE;
      end
    endcase
  end

  // Next state follows whichever entry will sit at the head after this edge
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = q_count_s + (PW+1)'(1);
      2'b01:   cnt_nxt_s = q_count_s - (PW+1)'(1);
      default: cnt_nxt_s = q_count_s;
    endcase
    if (pop_s) begin
      nsrc_s = (q_count_s >= (PW+1)'(2)) ? q_next_src_s : req_src_sel;
    end else begin
      nsrc_s = q_empty_s ? req_src_sel : q_head_s.src_sel;
    end
    if (cnt_nxt_s == (PW+1)'(0)) begin
      state_d = ST_EMPTY;
    end else if (is_load(nsrc_s)) begin
      state_d = ST_WAIT_MEM;
    end else begin
      state_d = ST_ISSUE;
    end
  end

  // Hazard mask: OR of one-hot targets of every occupied slot
  always_comb begin
    pend_mask_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_mask_s = pend_mask_s | (q_vld_s[i] ? reg_onehot(q_addr_s[i]) : 32'd0);
    end
  end

  // State and registered write-port outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_EMPTY;
      wb_sel_q  <= WB_NONE;
      wb_addr_q <= 5'd0;
      wb_data_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_sel_q  <= wb_sel_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign wb_writeReg  = wb_sel_q;
  assign wb_addr      = wb_addr_q;
  assign wb_writeData = wb_data_q;
  assign err          = err_q;
  assign pend_mask    = pend_mask_s;

endmodule

// File: tb/tb_writeback_sequencer.sv
module tb_writeback_sequencer;
  import kgp_wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_dst_sel;
  logic [1:0]  req_src_sel;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [31:0] req_alu_result;
  logic [31:0] req_pc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  wb_writeReg;
  logic [4:0]  wb_addr;
  logic [31:0] wb_writeData;
  logic [31:0] pend_mask;
  logic        err;

  writeback_sequencer #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_dst_sel    (req_dst_sel),
    .req_src_sel    (req_src_sel),
    .req_rs         (req_rs),
    .req_rt         (req_rt),
    .req_alu_result (req_alu_result),
    .req_pc         (req_pc),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .wb_writeReg    (wb_writeReg),
    .wb_addr        (wb_addr),
    .wb_writeData   (wb_writeData),
    .pend_mask      (pend_mask),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected just after the next edge
  typedef struct {
    logic        v;
    logic [1:0]  dst;
    logic [1:0]  src;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        mv;
    logic [31:0] md;
    logic [1:0]  e_sel;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_mask;
    logic        e_err;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];
  vec_t t;
  int   checks;
  int   errors;

  task automatic cmp(input string name, input int idx, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] %s: got %h, expected %h", name, idx, field, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int idx, input vec_t x);
    cmp(name, idx, "wb_writeReg",  {30'd0, wb_writeReg}, {30'd0, x.e_sel});
    cmp(name, idx, "wb_addr",      {27'd0, wb_addr},     {27'd0, x.e_addr});
    cmp(name, idx, "wb_writeData", wb_writeData,         x.e_data);
    cmp(name, idx, "pend_mask",    pend_mask,            x.e_mask);
    cmp(name, idx, "err",          {31'd0, err},         {31'd0, x.e_err});
    cmp(name, idx, "req_ready",    {31'd0, req_ready},   {31'd0, x.e_rdy});
  endtask

  task automatic drive(input vec_t x);
    req_valid      = x.v;
    req_dst_sel    = x.dst;
    req_src_sel    = x.src;
    req_rs         = x.rs;
    req_rt         = x.rt;
    req_alu_result = x.alu;
    req_pc         = x.pc;
    mem_rvalid     = x.mv;
    mem_rdata      = x.md;
  endtask

  task automatic step(input vec_t x, input string name, input int idx);
    @(negedge clk);
    drive(x);
    @(posedge clk);
    #1;
    check_out(name, idx, x);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    t = '{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0,
          WB_NONE, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0};
    drive(t);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 0, t);
    @(negedge clk);
    rst = 1'b1;

    // Cycle table: {v,dst,src,rs,rt,alu,pc,mv,md | sel,addr,data,mask,err,rdy}
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, WB_RS, SRC_ALU, 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd0, 32'd0, 32'h20, 1'b0, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_RS, 5'd5, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd5, 32'hDEADBEEF, 32'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, WB_LINK, SRC_LINK, 5'd0, 5'd0, 32'd0, 32'hFFFFFFFC, 1'b0, 32'd0, WB_NONE, 5'd5, 32'hDEADBEEF, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_LINK, 5'd31, 32'd0, 32'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, WB_RT, SRC_MEM, 5'd9, 5'd7, 32'h5555, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd31, 32'd0, 32'h80, 1'b0, 1'b1});
    vecs.push_back('{1'b1, WB_RS, SRC_ALU, 5'd3, 5'd0, 32'd1, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd31, 32'd0, 32'h88, 1'b0, 1'b0});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd31, 32'd0, 32'h88, 1'b0, 1'b0});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd31, 32'd0, 32'h88, 1'b0, 1'b0});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 32'h1234, WB_RT, 5'd7, 32'h1234, 32'h08, 1'b0, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_RS, 5'd3, 32'd1, 32'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd3, 32'd1, 32'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, WB_NONE, SRC_ALU, 5'd9, 5'd0, 32'd55, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd3, 32'd1, 32'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd3, 32'd1, 32'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 32'hAAAA, WB_NONE, 5'd3, 32'd1, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd3, 32'd1, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, WB_RT, 2'b11, 5'd1, 5'd12, 32'h77, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd3, 32'd1, 32'h1000, 1'b1, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_RT, 5'd12, 32'h77, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, WB_RS, SRC_ALU, 5'd1, 5'd0, 32'h11, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd12, 32'h77, 32'h2, 1'b1, 1'b1});
    vecs.push_back('{1'b1, WB_RS, SRC_ALU, 5'd2, 5'd0, 32'h22, 32'd0, 1'b0, 32'd0, WB_RS, 5'd1, 32'h11, 32'h4, 1'b1, 1'b1});
    vecs.push_back('{1'b1, WB_RT, SRC_ALU, 5'd0, 5'd4, 32'h44, 32'd0, 1'b0, 32'd0, WB_RS, 5'd2, 32'h22, 32'h10, 1'b1, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_RT, 5'd4, 32'h44, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, WB_RS, SRC_MEM, 5'd6, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd4, 32'h44, 32'h40, 1'b1, 1'b1});
    vecs.push_back('{1'b1, WB_RS, SRC_ALU, 5'd8, 5'd0, 32'h88, 32'd0, 1'b1, 32'hBEEF, WB_RS, 5'd6, 32'hBEEF, 32'h100, 1'b1, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_RS, 5'd8, 32'h88, 32'd0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd8, 32'h88, 32'd0, 1'b1, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], "table", i);
    end

    // Back-pressure: load stalls, queue fills, held request waits for a pop
    t = '{1'b1, WB_RT, SRC_MEM, 5'd0, 5'd10, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd8, 32'h88, 32'h400, 1'b1, 1'b1};
    step(t, "bp", 0);
    t = '{1'b1, WB_RS, SRC_ALU, 5'd11, 5'd0, 32'hB1, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd8, 32'h88, 32'hC00, 1'b1, 1'b0};
    step(t, "bp", 1);
    t = '{1'b1, WB_RS, SRC_ALU, 5'd12, 5'd0, 32'hB2, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd8, 32'h88, 32'hC00, 1'b1, 1'b0};
    for (int k = 2; k < 5; k++) begin
      step(t, "bp", k);
    end
    t = '{1'b1, WB_RS, SRC_ALU, 5'd12, 5'd0, 32'hB2, 32'd0, 1'b1, 32'h5, WB_RT, 5'd10, 32'h5, 32'h800, 1'b1, 1'b1};
    step(t, "bp", 5);
    t = '{1'b1, WB_RS, SRC_ALU, 5'd12, 5'd0, 32'hB2, 32'd0, 1'b0, 32'd0, WB_RS, 5'd11, 32'hB1, 32'h1000, 1'b1, 1'b1};
    step(t, "bp", 6);
    t = '{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_RS, 5'd12, 32'hB2, 32'd0, 1'b1, 1'b1};
    step(t, "bp", 7);
    t = '{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd12, 32'hB2, 32'd0, 1'b1, 1'b1};
    step(t, "bp", 8);

    // Asynchronous reset while a load waits with a second entry queued
    t = '{1'b1, WB_RT, SRC_MEM, 5'd0, 5'd13, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd12, 32'hB2, 32'h2000, 1'b1, 1'b1};
    step(t, "rstq", 0);
    t = '{1'b1, WB_RS, SRC_ALU, 5'd14, 5'd0, 32'hC4, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd12, 32'hB2, 32'h6000, 1'b1, 1'b0};
    step(t, "rstq", 1);
    @(negedge clk);
    t = '{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0};
    drive(t);
    #2;
    rst = 1'b0;
    #1;
    check_out("rst_async", 0, t);
    @(posedge clk);
    #1;
    check_out("rst_async", 1, t);
    @(negedge clk);
    rst = 1'b1;
    t = '{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1};
    step(t, "post_rst", 0);
    step(t, "post_rst", 1);
    t = '{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b1, 32'h99, WB_NONE, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1};
    step(t, "post_rst", 2);
    t = '{1'b0, WB_NONE, SRC_ALU, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, WB_NONE, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1};
    step(t, "post_rst", 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
